// File: rtl/ysyx_23060191_div.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow skip the iteration and finish on the next cycle.
module ysyx_23060191_div #(
    parameter int CPU_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [CPU_WIDTH-1:0] i_div_in1,
    input  logic [CPU_WIDTH-1:0] i_div_in2,
    input  logic                 i_div_signed,
    input  logic                 i_div_rem_sel,
    output logic                 o_res_valid,
    input  logic                 i_res_ready,
    output logic [CPU_WIDTH-1:0] o_div_res
);

    localparam int CW = $clog2(CPU_WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(CPU_WIDTH - 1);
    localparam logic [CPU_WIDTH-1:0] MOST_NEG = {1'b1, {(CPU_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [CW-1:0]        cnt;
    logic [CPU_WIDTH-1:0] quo;
    logic [CPU_WIDTH:0]   rem;
    logic [CPU_WIDTH-1:0] dsr;
    logic                 sgn;
    logic                 rsel;
    logic                 neg1;
    logic                 neg2;
    logic                 special;

    logic                 accept;
    logic                 in1_neg;
    logic                 in2_neg;
    logic [CPU_WIDTH-1:0] abs1;
    logic [CPU_WIDTH-1:0] abs2;
    logic                 div_zero;
    logic                 div_ovf;

    logic [CPU_WIDTH+1:0] shifted;
    logic [CPU_WIDTH+1:0] diff;
    logic                 fits;
    logic [CPU_WIDTH-1:0] quo_fix;
    logic [CPU_WIDTH-1:0] rem_fix;

    assign accept   = i_req_valid & (state == IDLE) & ~i_flush;
    assign in1_neg  = i_div_signed & i_div_in1[CPU_WIDTH-1];
    assign in2_neg  = i_div_signed & i_div_in2[CPU_WIDTH-1];
    assign abs1     = in1_neg ? (~i_div_in1 + 1'b1) : i_div_in1;
    assign abs2     = in2_neg ? (~i_div_in2 + 1'b1) : i_div_in2;
    assign div_zero = (i_div_in2 == '0);
    assign div_ovf  = i_div_signed & (i_div_in1 == MOST_NEG) & (i_div_in2 == '1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        o_req_ready = 1'b0;
        o_res_valid = 1'b0;
        case (state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (accept) begin
                    next_state = (div_zero | div_ovf) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == LAST_STEP) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                o_res_valid = 1'b1;
                if (i_res_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (i_flush) begin
            next_state = IDLE;
        end
    end

    // One restoring step: bring in the next dividend bit and subtract if it fits.
    assign shifted = {rem, quo[CPU_WIDTH-1]};
    assign diff    = shifted - {2'b00, dsr};
    assign fits    = ~diff[CPU_WIDTH+1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt     <= '0;
            quo     <= '0;
            rem     <= '0;
            dsr     <= '0;
            sgn     <= 1'b0;
            rsel    <= 1'b0;
            neg1    <= 1'b0;
            neg2    <= 1'b0;
            special <= 1'b0;
        end else if (accept) begin
            cnt  <= '0;
            dsr  <= abs2;
            sgn  <= i_div_signed;
            rsel <= i_div_rem_sel;
            neg1 <= in1_neg;
            neg2 <= in2_neg;
            if (div_zero) begin
                quo     <= '1;
                rem     <= {1'b0, i_div_in1};
                special <= 1'b1;
            end else if (div_ovf) begin
                quo     <= MOST_NEG;
                rem     <= '0;
                special <= 1'b1;
            end else begin
                quo     <= abs1;
                rem     <= '0;
                special <= 1'b0;
            end
        end else if (state == CALC && !i_flush) begin
            rem <= fits ? diff[CPU_WIDTH:0] : shifted[CPU_WIDTH:0];
            quo <= {quo[CPU_WIDTH-2:0], fits};
            cnt <= cnt + 1'b1;
        end
    end

    // Special-case results are stored already final, so they bypass the sign fixups.
    assign quo_fix = (sgn & (neg1 ^ neg2) & ~special) ? (~quo + 1'b1) : quo;
    assign rem_fix = (sgn & neg1 & ~special) ? (~rem[CPU_WIDTH-1:0] + 1'b1) : rem[CPU_WIDTH-1:0];

    assign o_div_res = (state == DONE) ? (rsel ? rem_fix : quo_fix) : '0;

endmodule

// File: tb/tb_ysyx_23060191_div.sv
// Directed and random checks of ysyx_23060191_div against a reference model.
module tb_ysyx_23060191_div;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        sgn;
    logic        rsel;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    ysyx_23060191_div #(.CPU_WIDTH(32)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_flush       (flush),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_div_in1     (in1),
        .i_div_in2     (in2),
        .i_div_signed  (sgn),
        .i_div_rem_sel (rsel),
        .o_res_valid   (res_valid),
        .i_res_ready   (res_ready),
        .o_div_res     (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input logic r);
        if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : 32'h8000_0000;
        if (s) return r ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return r ? a % b : a / b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (res_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Issues one request, then checks latency, result, optional back-pressure and release.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic r, input bit hold);
        logic [31:0] exp;
        int lat;
        int exp_lat;
        check("ready_before", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        in1 = a;
        in2 = b;
        sgn = s;
        rsel = r;
        exp_q.push_back(model(a, b, s, r));
        exp_lat = (b == 32'd0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        in1 = $urandom;
        in2 = $urandom;
        sgn = ~s;
        rsel = ~r;
        wait_result(lat);
        check("latency", 32'(lat), 32'(exp_lat));
        exp = exp_q.pop_front();
        check("result", res, exp);
        check("ready_in_done", {31'd0, req_ready}, 32'd0);
        if (hold) begin
            repeat (5) begin
                @(posedge clk);
                #1;
                check("hold_valid", {31'd0, res_valid}, 32'd1);
                check("hold_res", res, exp);
            end
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("release_valid", {31'd0, res_valid}, 32'd0);
        check("release_ready", {31'd0, req_ready}, 32'd1);
        check("idle_res", res, 32'd0);
    endtask

    // Starts a long division and kills it while the step counter is at 10.
    task automatic abort_op(input bit use_rst);
        logic saw;
        saw = 1'b0;
        req_valid = 1'b1;
        in1 = 32'd1000;
        in2 = 32'd7;
        sgn = 1'b0;
        rsel = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (res_valid) saw = 1'b1;
        end
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush = 1'b0;
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_res", res, 32'd0);
        repeat (40) begin
            @(posedge clk);
            #1;
            if (res_valid) saw = 1'b1;
        end
        check("abort_never_valid", {31'd0, saw}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        req_valid = 1'b0;
        in1 = '0;
        in2 = '0;
        sgn = 1'b0;
        rsel = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_valid", {31'd0, res_valid}, 32'd0);
        check("reset_res", res, 32'd0);

        run_op(32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
        run_op(32'd100, 32'd7, 1'b0, 1'b1, 1'b0);
        run_op(-32'sd7, 32'd2, 1'b1, 1'b0, 1'b0);
        run_op(-32'sd7, 32'd2, 1'b1, 1'b1, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_op(32'd1234, 32'd0, 1'b0, 1'b0, 1'b0);
        run_op(32'd1234, 32'd0, 1'b0, 1'b1, 1'b0);
        run_op(32'd1234, 32'd0, 1'b1, 1'b0, 1'b0);
        run_op(32'd1234, 32'd0, 1'b1, 1'b1, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_op(32'd50, -32'sd3, 1'b1, 1'b1, 1'b1);
        run_op(32'd123456, 32'd789, 1'b0, 1'b0, 1'b1);

        // Flush together with a request in IDLE must not accept it.
        flush = 1'b1;
        req_valid = 1'b1;
        in1 = 32'd1234;
        in2 = 32'd0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        req_valid = 1'b0;
        check("flush_req_ready", {31'd0, req_ready}, 32'd1);
        check("flush_req_valid", {31'd0, res_valid}, 32'd0);

        abort_op(1'b0);
        run_op(32'd9, 32'd3, 1'b0, 1'b0, 1'b0);
        abort_op(1'b1);
        run_op(32'd9, 32'd3, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_op($urandom, $urandom_range(1, 100000), i[0], i[1], 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            run_op($urandom, $urandom, 1'b1, i[0], 1'b0);
        end

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_23060191_div.md
YSYX_23060191_DIV -- requirements
Module: ysyx_23060191_DIV

Interface
REQ-001 SHALL have parameter CPU_WIDTH, default 32, giving operand/result width; all values below assume 32.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have port i_flush  input  1  abort any in-flight operation.
REQ-005 SHALL have port i_req_valid  input  1  request offered by execute stage.
REQ-006 SHALL have port o_req_ready  output  1  divider can accept a request.
REQ-007 SHALL have port i_div_in1  input  CPU_WIDTH  dividend.
REQ-008 SHALL have port i_div_in2  input  CPU_WIDTH  divisor.
REQ-009 SHALL have port i_div_signed  input  1  1 = DIV/REM, 0 = DIVU/REMU.
REQ-010 SHALL have port i_div_rem_sel  input  1  1 = return remainder, 0 = return quotient.
REQ-011 SHALL have port o_res_valid  output  1  result available.
REQ-012 SHALL have port i_res_ready  input  1  execute stage consumes result.
REQ-013 SHALL have port o_div_res  output  CPU_WIDTH  quotient or remainder.

Function
REQ-014 SHALL implement states IDLE, CALC, DONE; o_req_ready = 1 only in IDLE; o_res_valid = 1 only in DONE.
REQ-015 SHALL accept a request on a cycle where i_req_valid & o_req_ready, latching in1, in2, signed, rem_sel; inputs ignored at all other times.
REQ-016 SHALL, on acceptance with divisor != 0 and not signed overflow, enter CALC with iteration counter = 0, operands converted to magnitudes when signed.
REQ-017 SHALL perform one restoring shift-subtract step per CALC cycle, 32 steps, counter 0..31; after step 31 enter DONE.
REQ-018 SHALL therefore assert o_res_valid exactly 33 cycles after the accept edge for normal operations.
REQ-019 SHALL in DONE apply sign fixups: quotient negated when signed and operand signs differ; remainder takes dividend sign.
REQ-020 SHALL on divisor == 0 go IDLE -> DONE directly (o_res_valid next cycle), quotient = 0xFFFFFFFF, remainder = dividend.
REQ-021 SHALL on signed dividend 0x80000000 with divisor 0xFFFFFFFF go IDLE -> DONE directly, quotient = 0x80000000, remainder = 0.
REQ-022 SHALL hold o_div_res stable while in DONE and o_res_valid & !i_res_ready.
REQ-023 SHALL leave DONE for IDLE on the cycle o_res_valid & i_res_ready; no new request accepted in that same cycle (o_req_ready still 0).
REQ-024 SHALL on i_flush = 1 go to IDLE next cycle from any state, discarding the operation; flush in IDLE has no effect; flush together with i_req_valid in IDLE does not accept.
REQ-025 SHALL drive o_div_res = 0 whenever not in DONE.
REQ-026 SHALL use 33-bit internal partial remainder so unsigned 0xFFFFFFFF operands do not overflow.

Reset
REQ-027 SHALL on i_rst = 1 at a clock edge enter IDLE, clear counter and latched operands, regardless of state (including mid-CALC).
REQ-028 SHALL present after reset: o_req_ready = 1, o_res_valid = 0, o_div_res = 0.
REQ-029 SHALL give i_rst priority over i_flush and over any handshake in the same cycle.

Verification
REQ-030 SHALL be verified: unsigned 100 / 7, rem_sel=0 -> o_res_valid at accept+33, o_div_res = 14; rem_sel=1 -> 2.
REQ-031 SHALL be verified: signed -7 / 2 -> quotient 0xFFFFFFFD (-3); rem -> 0xFFFFFFFF (-1); unsigned 0xFFFFFFFF / 1 -> 0xFFFFFFFF.
REQ-032 SHALL be verified: 1234 / 0 -> o_res_valid at accept+1, quotient 0xFFFFFFFF, remainder 1234 (signed and unsigned).
REQ-033 SHALL be verified: signed 0x80000000 / 0xFFFFFFFF -> accept+1, quotient 0x80000000, remainder 0.
REQ-034 SHALL be verified: i_res_ready held 0 for 5 cycles in DONE -> o_res_valid and o_div_res constant; ready=1 -> IDLE next cycle, o_req_ready = 1.
REQ-035 SHALL be verified: i_rst or i_flush pulsed at CALC counter 10 -> IDLE next cycle, o_res_valid never asserted; following request 9 / 3 returns 3 at accept+33.
